multicycle_control_fsm: RTL and testbench

Multi-cycle sequencer for the single-issue MIPS datapath (program counter, instruction memory, register file, ALU, data memory, sign extension, select muxes). It latches each fetched instruction and steps it through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. At each step it drives PC control, write enables, mux selects and ALU control. Data-memory accesses use a req/ready handshake with a bounded wait.

---
 rtl/cpu_defs_pkg.sv | 64 ++++++
 rtl/instr_decoder.sv | 83 ++++++++
 rtl/multicycle_control_fsm.sv | 155 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, functs, PC/ALU ops, FSM states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package cpu_defs_pkg;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (ir[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    PC_HOLD   = 4'd0,
    PC_INC    = 4'd1,
    PC_JUMP   = 4'd2,
    PC_BRANCH = 4'd3,
    PC_REG    = 4'd4
  } pc_ctrl_t;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  // Coarse instruction class; drives the FSM's path through the steps
  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_JR      = 4'd1,
    CLS_ADDI    = 4'd2,
    CLS_LW      = 4'd3,
    CLS_SW      = 4'd4,
    CLS_BEQ     = 4'd5,
    CLS_BNE     = 4'd6,
    CLS_J       = 4'd7,
    CLS_ILLEGAL = 4'd8
  } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Instruction decoder: maps opcode/funct/register fields to class, ALU op, selects and flags.
// Latency: purely combinational.
// Backpressure: none; outputs follow the ir fields directly.
module instr_decoder
  import cpu_defs_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  output instr_class_t instr_class,
  output logic [3:0]   alu_control,
  output logic         alu_mux_select,
  output logic         rmux_select,
  output logic         dmux_select,
  output logic         dest_is_zero,
  output logic         illegal
);

  // Classify the instruction and pick its ALU op and datapath selects
  always_comb begin
    instr_class    = CLS_ILLEGAL;
    alu_control    = ALU_AND;
    alu_mux_select = 1'b0;
    rmux_select    = 1'b0;
    dmux_select    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        instr_class = CLS_ALU_R;
        rmux_select = 1'b1;
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          FN_SLL:  alu_control = ALU_SLL;
          FN_SRL:  alu_control = ALU_SRL;
          FN_JR: begin
            instr_class = CLS_JR;
            rmux_select = 1'b0;
            alu_control = ALU_ADD;
          end
          default: begin
            instr_class = CLS_ILLEGAL;
            rmux_select = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        instr_class    = CLS_ADDI;
        alu_control    = ALU_ADD;
        alu_mux_select = 1'b1;
      end
      OP_LW: begin
        instr_class    = CLS_LW;
        alu_control    = ALU_ADD;
        alu_mux_select = 1'b1;
        dmux_select    = 1'b1;
      end
      OP_SW: begin
        instr_class    = CLS_SW;
        alu_control    = ALU_ADD;
        alu_mux_select = 1'b1;
      end
      OP_BEQ: begin
        instr_class = CLS_BEQ;
        alu_control = ALU_SUB;
      end
      OP_BNE: begin
        instr_class = CLS_BNE;
        alu_control = ALU_SUB;
      end
      OP_J:    instr_class = CLS_J;
      default: instr_class = CLS_ILLEGAL;
    endcase
  end

  // R-type writes rd, immediate forms write rt; $0 writes are dropped upstream
  assign dest_is_zero = (instr_class == CLS_ALU_R) ? (rd == 5'd0) : (rt == 5'd0);
  assign illegal      = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencer: latches the instruction and steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Latency: 3 cycles branch/jump, 4 R-type/addi, 4+wait sw, 5+wait lw.
// Backpressure: MEMORY holds req until mem_ready, abandoning after MEM_TIMEOUT idle cycles.
module multicycle_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [31:0]      ir,
  output logic [3:0]       pc_control,
  output logic             reg_file_wren,
  output logic             reg_file_rmux_select,
  output logic             reg_file_dmux_select,
  output logic             alu_mux_select,
  output logic [3:0]       alu_control,
  output logic [4:0]       alu_shamt,
  output logic             data_mem_req,
  output logic             data_mem_wren,
  output logic             illegal_instr,
  output logic             mem_error,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout;

  instr_class_t      dec_class;
  logic [3:0]        dec_alu_control;
  logic              dec_alu_mux;
  logic              dec_rmux;
  logic              dec_dmux;
  logic              dec_dest_zero;
  logic              dec_illegal;

  instr_decoder u_instr_decoder (
    .opcode         (ir[31:26]),
    .funct          (ir[5:0]),
    .rt             (ir[20:16]),
    .rd             (ir[15:11]),
    .instr_class    (dec_class),
    .alu_control    (dec_alu_control),
    .alu_mux_select (dec_alu_mux),
    .rmux_select    (dec_rmux),
    .dmux_select    (dec_dmux),
    .dest_is_zero   (dec_dest_zero),
    .illegal        (dec_illegal)
  );

  // Timeout wins over a late mem_ready: once the budget is spent the request is already dropped
  assign mem_timeout = (state == MEMORY) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // Per-step datapath controls; every output idles at 0 outside the step that needs it
  always_comb begin
    pc_control           = PC_HOLD;
    reg_file_wren        = 1'b0;
    reg_file_rmux_select = 1'b0;
    reg_file_dmux_select = 1'b0;
    alu_mux_select       = 1'b0;
    alu_control          = ALU_AND;
    alu_shamt            = 5'd0;
    data_mem_req         = 1'b0;
    data_mem_wren        = 1'b0;
    illegal_instr        = 1'b0;
    case (state)
      DECODE: illegal_instr = dec_illegal;
      EXECUTE: begin
        alu_control    = dec_alu_control;
        alu_mux_select = dec_alu_mux;
        alu_shamt      = ir[10:6];
        case (dec_class)
          CLS_BEQ: pc_control = alu_zero ? PC_BRANCH : PC_INC;
          CLS_BNE: pc_control = alu_zero ? PC_INC : PC_BRANCH;
          CLS_J:   pc_control = PC_JUMP;
          CLS_JR:  pc_control = PC_REG;
          default: pc_control = PC_HOLD;
        endcase
      end
      MEMORY: begin
        // Keep the address computation stable for the whole access
        alu_control    = dec_alu_control;
        alu_mux_select = dec_alu_mux;
        alu_shamt      = ir[10:6];
        if (mem_timeout) begin
          pc_control = PC_INC;
        end else begin
          data_mem_req  = 1'b1;
          data_mem_wren = (dec_class == CLS_SW);
          if (mem_ready && (dec_class == CLS_SW)) pc_control = PC_INC;
        end
      end
      WRITEBACK: begin
        alu_control          = dec_alu_control;
        alu_mux_select       = dec_alu_mux;
        alu_shamt            = ir[10:6];
        reg_file_rmux_select = dec_rmux;
        reg_file_dmux_select = dec_dmux;
        reg_file_wren        = !dec_dest_zero && !dec_illegal;
        pc_control           = PC_INC;
      end
      default: ;
    endcase
  end

  // Step sequencing, instruction latch, memory wait budget and retirement count
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      ir            <= 32'd0;
      mem_error     <= 1'b0;
      instr_retired <= '0;
      wait_cnt      <= '0;
    end else begin
      // An instruction retires exactly when it moves the PC
      if (pc_control != PC_HOLD) instr_retired <= instr_retired + CNT_W'(1);
      case (state)
        FETCH: begin
          ir    <= instruction;
          state <= DECODE;
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          case (dec_class)
            CLS_BEQ, CLS_BNE, CLS_J, CLS_JR: state <= FETCH;
            CLS_LW, CLS_SW:                  state <= MEMORY;
            default:                         state <= WRITEBACK;
          endcase
        end
        MEMORY: begin
          if (mem_timeout) begin
            mem_error <= 1'b1;
            wait_cnt  <= '0;
            state     <= FETCH;
          end else if (mem_ready) begin
            wait_cnt <= '0;
            state    <= (dec_class == CLS_LW) ? WRITEBACK : FETCH;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        WRITEBACK: state <= FETCH;
        default:   state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: directed and random instructions against a per-instruction timing model.
// Latency: model derives cycle count and retiring-cycle controls from the instruction class.
// Backpressure: mem_ready delays are chosen per instruction, including timeout cases.
module tb_multicycle_control_fsm;

  localparam int T = 15;

  localparam int C_R    = 0;
  localparam int C_JR   = 1;
  localparam int C_ADDI = 2;
  localparam int C_LW   = 3;
  localparam int C_SW   = 4;
  localparam int C_BEQ  = 5;
  localparam int C_BNE  = 6;
  localparam int C_J    = 7;
  localparam int C_ILL  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        mem_ready;
  logic [31:0] ir;
  logic [3:0]  pc_control;
  logic        reg_file_wren;
  logic        reg_file_rmux_select;
  logic        reg_file_dmux_select;
  logic        alu_mux_select;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic        data_mem_req;
  logic        data_mem_wren;
  logic        illegal_instr;
  logic        mem_error;
  logic [31:0] instr_retired;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_retired;
  bit exp_mem_err;

  multicycle_control_fsm #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .instruction          (instruction),
    .alu_zero             (alu_zero),
    .mem_ready            (mem_ready),
    .ir                   (ir),
    .pc_control           (pc_control),
    .reg_file_wren        (reg_file_wren),
    .reg_file_rmux_select (reg_file_rmux_select),
    .reg_file_dmux_select (reg_file_dmux_select),
    .alu_mux_select       (alu_mux_select),
    .alu_control          (alu_control),
    .alu_shamt            (alu_shamt),
    .data_mem_req         (data_mem_req),
    .data_mem_wren        (data_mem_wren),
    .illegal_instr        (illegal_instr),
    .mem_error            (mem_error),
    .instr_retired        (instr_retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural classification straight from the ISA tables
  function automatic int cls_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: return C_R;
          6'h08:   return C_JR;
          default: return C_ILL;
        endcase
      end
      6'h08:   return C_ADDI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h05:   return C_BNE;
      6'h02:   return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int alu_of(input logic [31:0] ins);
    case (cls_of(ins))
      C_R: begin
        case (ins[5:0])
          6'h20:   return 2;
          6'h22:   return 6;
          6'h24:   return 0;
          6'h25:   return 1;
          6'h2A:   return 7;
          6'h00:   return 8;
          default: return 9;
        endcase
      end
      C_ADDI, C_LW, C_SW: return 2;
      C_BEQ, C_BNE:       return 6;
      default:            return 0;
    endcase
  endfunction

  // Runs one instruction starting just after a FETCH-cycle clock edge.
  // wait_cyc: mem_ready rises after that many unready MEMORY cycles; >= T means never.
  // az_mode: -1 random alu_zero, else the fixed value.
  task automatic run_instr(input logic [31:0] ins, input int wait_cyc, input int az_mode);
    int         c;
    int         n;
    int         req_cyc;
    bit         is_mem;
    bit         timed_out;
    bit         writes_back;
    bit         dest_zero;
    bit         wb_en;
    bit         req_exp;
    bit         az;
    logic [3:0] exp_pc;
    c         = cls_of(ins);
    is_mem    = (c == C_LW) || (c == C_SW);
    timed_out = is_mem && (wait_cyc >= T);
    req_cyc   = !is_mem ? 0 : (timed_out ? T : wait_cyc + 1);
    case (c)
      C_BEQ, C_BNE, C_J, C_JR: n = 3;
      C_SW:    n = 3 + req_cyc + (timed_out ? 1 : 0);
      C_LW:    n = 3 + req_cyc + 1;
      default: n = 4;
    endcase
    writes_back = (c == C_R) || (c == C_ADDI) || (c == C_ILL) || (c == C_LW && !timed_out);
    dest_zero   = (c == C_R) ? (ins[15:11] == 5'd0) : (ins[20:16] == 5'd0);
    wb_en       = writes_back && (c != C_ILL) && !dest_zero;
    az          = 1'b0;
    for (int k = 0; k < n; k++) begin
      instruction = (k == 0) ? ins : $urandom;
      alu_zero    = (az_mode < 0) ? 1'($urandom_range(0, 1)) : az_mode[0];
      if (k == 2) az = alu_zero;
      if (is_mem && k >= 3) mem_ready = !timed_out && (k - 3 == wait_cyc);
      else                  mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_pc = 4'd0;
      if (k == n - 1) begin
        case (c)
          C_BEQ:   exp_pc = az ? 4'd3 : 4'd1;
          C_BNE:   exp_pc = az ? 4'd1 : 4'd3;
          C_J:     exp_pc = 4'd2;
          C_JR:    exp_pc = 4'd4;
          default: exp_pc = 4'd1;
        endcase
      end
      req_exp = is_mem && (k >= 3) && (k < 3 + req_cyc);
      check_eq("pc_control", 32'(pc_control), 32'(exp_pc));
      check_eq("reg_file_wren", 32'(reg_file_wren), 32'((k == n - 1) && wb_en));
      check_eq("data_mem_req", 32'(data_mem_req), 32'(req_exp));
      check_eq("data_mem_wren", 32'(data_mem_wren), 32'(req_exp && (c == C_SW)));
      check_eq("illegal_instr", 32'(illegal_instr), 32'((k == 1) && (c == C_ILL)));
      check_eq("mem_error", 32'(mem_error), 32'(exp_mem_err));
      check_eq("instr_retired", instr_retired, 32'(exp_retired));
      if (k == 0) check_eq("fetch_alu_control", 32'(alu_control), 32'd0);
      if (k >= 1) check_eq("ir", ir, ins);
      if (k == 2) begin
        check_eq("alu_shamt", 32'(alu_shamt), 32'(ins[10:6]));
        check_eq("alu_mux_select", 32'(alu_mux_select),
                 32'((c == C_ADDI) || (c == C_LW) || (c == C_SW)));
        if (c != C_ILL && c != C_J && c != C_JR)
          check_eq("alu_control", 32'(alu_control), 32'(alu_of(ins)));
      end
      if (k == n - 1 && writes_back && c != C_ILL) begin
        check_eq("rmux_select", 32'(reg_file_rmux_select), 32'(c == C_R));
        check_eq("dmux_select", 32'(reg_file_dmux_select), 32'(c == C_LW));
      end
      @(posedge clk);
      #1;
    end
    exp_retired++;
    if (timed_out) exp_mem_err = 1'b1;
  endtask

  // Starts an sw, lets it wait in MEMORY, then resets mid-access.
  task automatic abort_sw_with_reset(input logic [31:0] ins, input int mem_cycles);
    for (int k = 0; k < 3 + mem_cycles; k++) begin
      instruction = (k == 0) ? ins : $urandom;
      alu_zero    = 1'($urandom_range(0, 1));
      mem_ready   = (k >= 3) ? 1'b0 : 1'($urandom_range(0, 1));
      if (k == 3 + mem_cycles - 1) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    // First cycle after the reset edge; rst stays high for one more edge
    @(negedge clk);
    check_eq("rst_abort_pc", 32'(pc_control), 32'd0);
    check_eq("rst_abort_req", 32'(data_mem_req), 32'd0);
    check_eq("rst_abort_dwren", 32'(data_mem_wren), 32'd0);
    check_eq("rst_abort_rwren", 32'(reg_file_wren), 32'd0);
    check_eq("rst_abort_ir", ir, 32'd0);
    check_eq("rst_abort_retired", instr_retired, 32'd0);
    check_eq("rst_abort_mem_error", 32'(mem_error), 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    exp_retired = 0;
    exp_mem_err = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  fn_list [7];
    int          sel;
    fn_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    r       = $urandom;
    sel     = $urandom_range(0, 10);
    case (sel)
      0, 1:    return {6'h00, r[25:6], fn_list[$urandom_range(0, 6)]};
      2:       return {6'h00, r[25:6], 6'h08};
      3:       return {6'h08, r[25:0]};
      4:       return {6'h23, r[25:0]};
      5:       return {6'h2B, r[25:0]};
      6:       return {6'h04, r[25:0]};
      7:       return {6'h05, r[25:0]};
      8:       return {6'h02, r[25:0]};
      9: begin
        while (cls_of(r) != C_ILL || r[31:26] == 6'h00) r = $urandom;
        return r;
      end
      default: begin
        r = {6'h00, r[25:0]};
        while (cls_of(r) != C_ILL) begin
          r = $urandom;
          r = {6'h00, r[25:0]};
        end
        return r;
      end
    endcase
  endfunction

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return $urandom_range(0, 4);
    if (r == 7) return T - 1;
    return T + 5;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    instruction = 32'd0;
    alu_zero    = 1'b0;
    mem_ready   = 1'b0;
    exp_retired = 0;
    exp_mem_err = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset_ir", ir, 32'd0);
    check_eq("reset_pc", 32'(pc_control), 32'd0);
    check_eq("reset_retired", instr_retired, 32'd0);
    check_eq("reset_mem_error", 32'(mem_error), 32'd0);
    check_eq("reset_req", 32'(data_mem_req), 32'd0);
    check_eq("reset_wren", 32'(reg_file_wren), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(32'h00221820, 0, -1);
    run_instr(32'h10220004, 0, 1);
    run_instr(32'h10220004, 0, 0);
    run_instr(32'h14220004, 0, 1);
    run_instr(32'h14220004, 0, 0);
    run_instr(32'h8C250008, 3, -1);
    run_instr(32'hAC250008, T - 1, -1);
    run_instr(32'h20000005, 0, -1);
    run_instr(32'hFC000000, 0, -1);
    run_instr(32'h00000000, 0, -1);
    run_instr(32'h08000010, 0, -1);
    run_instr(32'h03E00008, 0, -1);
    run_instr(32'hAC250008, T + 5, -1);
    run_instr(32'h00221820, 0, -1);
    run_instr(32'h8C250008, T, -1);

    abort_sw_with_reset(32'hAC250008, 11);
    run_instr(32'hAC250008, T - 1, -1);

    for (int i = 0; i < 300; i++) begin
      run_instr(rand_instr(), rand_wait(), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
